// File: rtl/pwm_pkg.sv
// pwm_pkg: register map, reset values and widths shared by the PWM bank.
// Imported by pwm_timebase and pwm_bank.
package pwm_pkg;

    localparam int ADDR_OUT_EN    = 'h00;
    localparam int ADDR_PWM_EN    = 'h01;
    localparam int ADDR_PERIOD    = 'h02;
    localparam int ADDR_PRESCALE  = 'h03;
    localparam int ADDR_DUTY_BASE = 'h04;

    localparam int PRESCALE_W = 4;

    localparam logic [7:0] RST_PERIOD = 8'hFF;
    localparam logic [7:0] RST_DUTY   = 8'h00;
    localparam logic [7:0] DUTY_FULL  = 8'hFF;

    localparam logic [PRESCALE_W-1:0] RST_PRESCALE = '0;

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler and period counter with a shadowed period.
// Drives the shadow-load strobe used by the channel duty registers.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [CNT_W-1:0]      period_stage,
    output logic [CNT_W-1:0]      cnt,
    output logic                  tick,
    output logic                  wrap,
    output logic                  shadow_load
);

    logic [PRESCALE_W-1:0] pre_cnt;
    logic [CNT_W-1:0]      period_active;

    // >= lets a PRESCALE lowered below pre_cnt tick at once
    assign tick        = (pre_cnt >= prescale);
    assign wrap        = tick && (cnt == period_active);
    assign shadow_load = wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt       <= '0;
            cnt           <= '0;
            period_active <= CNT_W'(RST_PERIOD);
        end else begin
            if (tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            if (wrap) begin
                cnt           <= '0;
                period_active <= period_stage;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM with shadowed PERIOD/DUTY registers.
// Define PWM_READBACK_EN to add the rd_en/rd_addr/rd_data read port.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
`ifdef PWM_READBACK_EN
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
`endif
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    logic [NUM_CH-1:0]            out_en;
    logic [NUM_CH-1:0]            pwm_en;
    logic [CNT_W-1:0]             period_stage;
    logic [PRESCALE_W-1:0]        prescale;
    logic [NUM_CH-1:0][CNT_W-1:0] duty_stage;
    logic [NUM_CH-1:0][CNT_W-1:0] duty_active;
    logic [NUM_CH-1:0]            duty_hit;

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             wrap;
    logic             shadow_load;
    logic             unused_tick;

    assign unused_tick = tick;

    always_ff @(posedge clk) begin
        assert (CNT_W == 8 && NUM_CH >= 1 && NUM_CH <= 8);
    end

    pwm_timebase #(
        .CNT_W(CNT_W)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .prescale    (prescale),
        .period_stage(period_stage),
        .cnt         (cnt),
        .tick        (tick),
        .wrap        (wrap),
        .shadow_load (shadow_load)
    );

    always_comb begin
        duty_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_hit[i] = wr_en &&
                (wr_addr == ADDR_W'(ADDR_DUTY_BASE + i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en       <= '0;
            pwm_en       <= '0;
            period_stage <= CNT_W'(RST_PERIOD);
            prescale     <= RST_PRESCALE;
            duty_stage   <= '{default: CNT_W'(RST_DUTY)};
            duty_active  <= '{default: CNT_W'(RST_DUTY)};
            period_start <= 1'b0;
        end else begin
            if (wr_en) begin
                unique case (1'b1)
                    (wr_addr == ADDR_W'(ADDR_OUT_EN)):
                        out_en <= wr_data[NUM_CH-1:0];
                    (wr_addr == ADDR_W'(ADDR_PWM_EN)):
                        pwm_en <= wr_data[NUM_CH-1:0];
                    (wr_addr == ADDR_W'(ADDR_PERIOD)):
                        period_stage <= CNT_W'(wr_data);
                    (wr_addr == ADDR_W'(ADDR_PRESCALE)):
                        prescale <= wr_data[PRESCALE_W-1:0];
                    default: ;
                endcase
            end
            // staging write and wrap on one edge: old staging is shadowed
            for (int i = 0; i < NUM_CH; i++) begin
                if (duty_hit[i]) begin
                    duty_stage[i] <= CNT_W'(wr_data);
                end
                if (shadow_load) begin
                    duty_active[i] <= duty_stage[i];
                end
            end
            period_start <= wrap;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic on;
        logic full;

        assign full = (duty_active[ch] == CNT_W'(DUTY_FULL));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                on <= 1'b0;
            end else begin
                on <= out_en[ch] && (!pwm_en[ch] || full ||
                      (cnt < duty_active[ch]));
            end
        end

        assign pwm_out[ch] = on;
    end

`ifdef PWM_READBACK_EN
    logic [7:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (rd_addr == ADDR_W'(ADDR_OUT_EN)):
                rd_mux[NUM_CH-1:0] = out_en;
            (rd_addr == ADDR_W'(ADDR_PWM_EN)):
                rd_mux[NUM_CH-1:0] = pwm_en;
            (rd_addr == ADDR_W'(ADDR_PERIOD)):
                rd_mux = 8'(period_stage);
            (rd_addr == ADDR_W'(ADDR_PRESCALE)):
                rd_mux[PRESCALE_W-1:0] = prescale;
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == ADDR_W'(ADDR_DUTY_BASE + i)) begin
                rd_mux = 8'(duty_stage[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_mux;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: scoreboard bench for pwm_bank (duty, period, prescale,
// shadowing, async reset; readback when PWM_READBACK_EN is defined).
module tb_pwm_bank;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [7:0]        wr_data = '0;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;
`ifdef PWM_READBACK_EN
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pwm_bank #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef PWM_READBACK_EN
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
`endif
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic score(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // negedges until period_start is seen, bounded
    task automatic ps_gap(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 3000);
        if (!period_start) chk("ps_timeout", 0, 1);
    endtask

    // one full period of channel ch, aligned to period_start
    task automatic measure(input int ch, input int len,
                           output int hi, output int end_ps);
        int n;
        ps_gap(n);
        hi = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            hi += int'(pwm_out[ch]);
        end
        end_ps = int'(period_start);
    endtask

`ifdef PWM_READBACK_EN
    task automatic rd(input logic [ADDR_W-1:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en   = 1'b0;
        d       = rd_data;
    endtask
`endif

    initial begin
        int n;
        int t;
        int hi;
        int eps;
        int h[2];
`ifdef PWM_READBACK_EN
        logic [7:0] d;
`endif

        repeat (3) @(negedge clk);
        expect_val("rst_pwm", 0);
        score(pwm_out);
        expect_val("rst_ps", 0);
        score(period_start);
        rst_n = 1'b1;

        expect_val("first_ps_gap", 256);
        ps_gap(n);
        score(n);
        expect_val("ps_gap_256", 256);
        ps_gap(n);
        score(n);
        expect_val("idle_pwm", 0);
        score(pwm_out);

        wr(7'h00, 8'h01);
        @(negedge clk);
        expect_val("static_high", 8'h01);
        score(pwm_out);

        wr(7'h01, 8'h01);
        wr(7'h04, 8'h80);
        ps_gap(n);
        expect_val("duty80_hi", 128);
        expect_val("duty80_len", 1);
        measure(0, 256, hi, eps);
        score(hi);
        score(eps);

        wr(7'h04, 8'hFF);
        ps_gap(n);
        expect_val("dutyFF_hi", 256);
        measure(0, 256, hi, eps);
        score(hi);

        wr(7'h04, 8'h00);
        ps_gap(n);
        expect_val("duty00_hi", 0);
        measure(0, 256, hi, eps);
        score(hi);

        wr(7'h04, 8'h40);
        ps_gap(n);
        ps_gap(n);
        expect_val("mid_cur_hi", 64);
        expect_val("mid_next_hi", 192);
        h[0] = 0;
        h[1] = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (i == 14) begin
                wr_en   = 1'b1;
                wr_addr = 7'h04;
                wr_data = 8'hC0;
            end else if (i == 15) begin
                wr_en = 1'b0;
            end
            h[i / 256] += int'(pwm_out[0]);
        end
        score(h[0]);
        score(h[1]);

        ps_gap(n);
        repeat (100) @(negedge clk);
        wr(7'h02, 8'h09);
        expect_val("shrink_cur_len", 256);
        ps_gap(n);
        t = 102 + n;
        score(t);
        expect_val("shrink_next_len", 10);
        ps_gap(n);
        score(n);
        expect_val("duty_gt_period", 10);
        measure(0, 10, hi, eps);
        score(hi);

        wr(7'h03, 8'h03);
        wr(7'h00, 8'h03);
        wr(7'h01, 8'h03);
        wr(7'h05, 8'h05);
        ps_gap(n);
        expect_val("pre3_hi", 20);
        expect_val("pre3_len", 1);
        measure(1, 40, hi, eps);
        score(hi);
        score(eps);

        wr(7'h7F, 8'hFF);
        wr(7'h0C, 8'hFF);
        expect_val("unmapped_hi", 20);
        expect_val("unmapped_len", 40);
        measure(1, 40, hi, eps);
        score(hi);
        ps_gap(n);
        score(n);
        expect_val("unmapped_upper", 0);
        score(32'(pwm_out[7:2]));

        ps_gap(n);
        repeat (2) @(negedge clk);
        expect_val("pre_rst_high", 1);
        score(pwm_out[1]);
        #2 rst_n = 1'b0;
        #1;
        expect_val("async_rst_pwm", 0);
        score(pwm_out);
        expect_val("async_rst_ps", 0);
        score(period_start);
        @(negedge clk);
        rst_n = 1'b1;
        expect_val("post_rst_gap", 256);
        ps_gap(n);
        score(n);
        expect_val("post_rst_pwm", 0);
        score(pwm_out);

`ifdef PWM_READBACK_EN
        wr(7'h02, 8'h3C);
        expect_val("rd_period", 8'h3C);
        rd(7'h02, d);
        score(d);
        expect_val("rd_hold", 8'h3C);
        @(negedge clk);
        score(rd_data);
        expect_val("rd_unmapped", 0);
        rd(7'h7F, d);
        score(d);
`endif

        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
